// File: rtl/reg_file_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_file_param: byte-writable multi-read-port register file with clear engine
// Revision: 1.0
// ---------------------------------------------------------------------------
module reg_file_param #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/8-1:0]        wr_be,
  input  logic                       clr_req,
  output logic                       busy,
  output logic                       wr_ack
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] be_mask;
  logic              wr_zero;
  logic              wr_commit;

  generate
    for (genvar b = 0; b < NB; b++) begin : g_mask
      assign be_mask[b*8 +: 8] = {8{wr_be[b]}};
    end
  endgenerate

  assign wr_zero   = (ZERO_R0 != 0) && (wr_addr == '0);
  assign busy      = (state == S_CLEAR);
  assign wr_ack    = wr_en & ~busy;
  assign wr_commit = wr_ack & ~wr_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_CLEAR;
      ptr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clr_req) begin
            state <= S_CLEAR;
            ptr   <= '0;
          end
        end
        S_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == {ADDR_W{1'b1}}) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Clear and write never coincide: a write is only accepted when not busy.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (busy)
        regs[ptr] <= '0;
      else if (wr_commit)
        regs[wr_addr] <= (regs[wr_addr] & ~be_mask) | (wr_data & be_mask);
    end
  end

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] stored;
      logic              hit;
      logic              zero_rd;

      assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
      assign stored  = regs[addr];
      assign hit     = (BYPASS != 0) && wr_commit && (addr == wr_addr);
      assign zero_rd = busy || ((ZERO_R0 != 0) && (addr == '0));

      assign rd_data[k*DATA_W +: DATA_W] =
        zero_rd ? '0 :
        hit     ? ((stored & ~be_mask) | (wr_data & be_mask)) :
                  stored;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reg_file_param: scoreboard bench for reg_file_param (BYPASS=1 and BYPASS=0)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        clr_req;
  logic        busy, busy_nb, wr_ack, wr_ack_nb;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [32];
  string       tag_q [$];
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  reg_file_param dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .clr_req(clr_req), .busy(busy), .wr_ack(wr_ack)
  );

  reg_file_param #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .clr_req(clr_req), .busy(busy_nb), .wr_ack(wr_ack_nb)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_pop(input logic [63:0] obs);
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 64'd1, 64'd0);
    end else begin
      check_eq(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_val(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    #1;
    check_eq("wr_ack", {63'd0, wr_ack}, 64'd1);
    @(posedge clk);
    if (a != 5'd0) model[a] = merge(model[a], d, be);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    @(negedge clk);
    rd_addr = {a1, a0};
    #1;
    sb_push("rd0", {32'd0, model_val(a0)});
    sb_push("rd1", {32'd0, model_val(a1)});
    sb_push("rd_nb", {model_val(a1), model_val(a0)});
    sb_pop({32'd0, rd_data[31:0]});
    sb_pop({32'd0, rd_data[63:32]});
    sb_pop(rd_data_nb);
  endtask

  // Called at a negedge with the clear running; returns busy cycle count.
  task automatic count_busy(output int n, input int wr_at);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      n++;
      rd_addr = 10'($urandom);
      if (n == wr_at) begin
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
      end
      #1;
      sb_push("busy_rd", 64'd0);
      sb_pop(rd_data);
      if (n == wr_at) check_eq("wr_ack_busy", {63'd0, wr_ack}, 64'd0);
      wr_en = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; wr_be = '0; clr_req = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;

    // One-cycle reset, then a full post-reset clear
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(n, 3);
    check_eq("reset_busy_len", 64'(n), 64'd32);
    read_all_zero();

    // Byte-enable merge
    wr(5'd5, 32'hDEAD_BEEF, 4'hF);
    wr(5'd5, 32'h0000_00AA, 4'h1);
    rd(5'd5, 5'd5);
    wr(5'd6, 32'h1122_3344, 4'hA);
    rd(5'd6, 5'd5);

    // Same-cycle forwarding versus registered read
    wr(5'd7, 32'h0BAD_F00D, 4'hF);
    @(negedge clk);
    rd_addr = {5'd7, 5'd7};
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678; wr_be = 4'hF;
    #1;
    sb_push("byp_new", 64'h1234_5678);
    sb_push("nobyp_old", 64'h0BAD_F00D);
    sb_pop({32'd0, rd_data[31:0]});
    sb_pop({32'd0, rd_data_nb[31:0]});
    @(posedge clk);
    model[7] = 32'h1234_5678;
    #1;
    wr_en = 1'b0;
    sb_push("nobyp_next", 64'h1234_5678);
    sb_pop({32'd0, rd_data_nb[31:0]});
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0099_0000; wr_be = 4'b0100;
    #1;
    sb_push("byp_partial", 64'h1299_5678);
    sb_pop({32'd0, rd_data[63:32]});
    @(posedge clk);
    model[7] = 32'h1299_5678;
    #1;
    wr_en = 1'b0;

    // Register 0 stays zero, including on the forwarding path
    @(negedge clk);
    rd_addr = {5'd0, 5'd0};
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
    #1;
    check_eq("r0_wr_ack", {63'd0, wr_ack}, 64'd1);
    sb_push("r0_byp", 64'd0);
    sb_pop(rd_data);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd(5'd0, 5'd0);

    // Fill, then clear with a coincident write and a dropped mid-clear write
    for (int i = 1; i < 32; i++) wr(5'(i), {8'(i), ~8'(i), 8'h5A, 8'(i)}, 4'hF);
    rd(5'd1, 5'd31);
    rd(5'd17, 5'd17);
    @(negedge clk);
    clr_req = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE_F00D; wr_be = 4'hF;
    #1;
    check_eq("clr_wr_ack", {63'd0, wr_ack}, 64'd1);
    @(posedge clk);
    #1;
    clr_req = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    count_busy(n, 10);
    check_eq("clear_busy_len", 64'(n), 64'd32);
    read_all_zero();

    // Reset in the middle of a clear restarts it
    wr(5'd2, 32'h0000_0002, 4'hF);
    wr(5'd30, 32'h3030_3030, 4'hF);
    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    @(negedge clk);
    repeat (14) @(negedge clk);
    check_eq("busy_at_15", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(n, 20);
    check_eq("restart_busy_len", 64'(n), 64'd32);
    read_all_zero();

    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
